// File: rtl/writeback.sv
// Writeback stage: registers memory-stage results, aligns sub-word loads,
// selects the register-file write value and stalls on late bus read data.
package writeback_pkg;
  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_t;
endpackage

module writeback
  import writeback_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_alu_result,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_pc_plus_4,
  input  mem_size_t   m_mem_size,
  input  logic        m_load_unsigned,
  input  logic [1:0]  m_result_src,
  input  logic        m_reg_write,
  input  logic [31:0] dbus_rd_data,
  input  logic        dbus_rd_valid,
  output logic        w_stall,
  output logic        w_reg_write,
  output logic [4:0]  w_rd,
  output logic [31:0] w_result,
  output logic        w_bus_error
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DONE} state_t;

  // The RUN cycle is the first stall cycle, so the timeout fires on the WAIT
  // cycle whose count is MAX_WAIT-1, giving MAX_WAIT stall cycles in total.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc_plus_4;
  mem_size_t   wb_mem_size;
  logic        wb_load_unsigned;
  logic [1:0]  wb_result_src;
  logic        wb_reg_write;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] hold_data;

  logic        is_load;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] aligned;

  assign is_load = (wb_result_src == 2'd1) && wb_reg_write;

  always_comb begin
    ld_byte = dbus_rd_data[7:0];
    case (wb_alu_result[1:0])
      2'd0: ld_byte = dbus_rd_data[7:0];
      2'd1: ld_byte = dbus_rd_data[15:8];
      2'd2: ld_byte = dbus_rd_data[23:16];
      2'd3: ld_byte = dbus_rd_data[31:24];
    endcase
    ld_half = wb_alu_result[1] ? dbus_rd_data[31:16] : dbus_rd_data[15:0];
    case (wb_mem_size)
      MEM_SIZE_BYTE: aligned = {{24{ld_byte[7] & ~wb_load_unsigned}}, ld_byte};
      MEM_SIZE_HALF: aligned = {{16{ld_half[15] & ~wb_load_unsigned}}, ld_half};
      default:       aligned = dbus_rd_data;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    case (state)
      ST_RUN:  w_stall = is_load && !dbus_rd_valid;
      ST_WAIT: w_stall = !dbus_rd_valid;
      default: w_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_result = wb_alu_result;
    if (state == ST_DONE) begin
      w_result = hold_data;
    end else if (state == ST_WAIT && dbus_rd_valid) begin
      w_result = aligned;
    end else begin
      case (wb_result_src)
        2'd1:    w_result = aligned;
        2'd2:    w_result = wb_pc_plus_4;
        default: w_result = wb_alu_result;
      endcase
    end
  end

  assign w_reg_write = wb_reg_write && (w_rd != 5'd0) && !w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_alu_result    <= '0;
      w_rd             <= '0;
      wb_pc_plus_4     <= '0;
      wb_mem_size      <= MEM_SIZE_BYTE;
      wb_load_unsigned <= 1'b0;
      wb_result_src    <= '0;
      wb_reg_write     <= 1'b0;
      state            <= ST_RUN;
      wait_cnt         <= '0;
      hold_data        <= '0;
      w_bus_error      <= 1'b0;
    end else begin
      if (!w_stall) begin
        wb_alu_result    <= m_alu_result;
        w_rd             <= m_rd;
        wb_pc_plus_4     <= m_pc_plus_4;
        wb_mem_size      <= m_mem_size;
        wb_load_unsigned <= m_load_unsigned;
        wb_result_src    <= m_result_src;
        wb_reg_write     <= m_reg_write;
      end
      case (state)
        ST_RUN: begin
          if (is_load && !dbus_rd_valid) begin
            if (MAX_WAIT == 1) begin
              w_bus_error <= 1'b1;
              hold_data   <= '0;
              state       <= ST_DONE;
            end else begin
              wait_cnt <= 8'd1;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dbus_rd_valid) begin
            hold_data <= aligned;
            state     <= ST_RUN;
          end else if (wait_cnt >= LAST_WAIT) begin
            w_bus_error <= 1'b1;
            hold_data   <= '0;
            state       <= ST_DONE;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
